// File: rtl/reg_bus_master.sv
// Bus-side initiator for the register file's shared port: sequences read/write
// strobes, owns the reg_data tristate and turnaround, returns one response per command.
module reg_bus_master #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 4,
  parameter int RD_LATENCY = 1,
  parameter int TURNAROUND = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy,
  output logic [ADDR_W-1:0] reg_addr,
  output logic              reg_r,
  output logic              reg_w,
  inout  wire  [DATA_W-1:0] reg_data
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_TURN     = 3'd3;
  localparam logic [2:0] S_WR       = 3'd4;
  localparam logic [2:0] S_RESP     = 3'd5;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RMW   = 2'b10;

  localparam int CNT_MAX = (RD_LATENCY > TURNAROUND) ? RD_LATENCY : TURNAROUND;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] wr_val;
  logic [DATA_W-1:0] rsp_rdata_d;
  logic              accept;
  logic              rd_done;

  assign accept  = cmd_valid & cmd_ready;
  assign rd_done = (state_q == S_RD_WAIT) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_READ, OP_RMW: state_d = S_RD_ISSUE;
            OP_WRITE:        state_d = S_WR;
            default:         state_d = S_RESP;
          endcase
        end
      end
      S_RD_ISSUE: begin
        state_d = S_RD_WAIT;
        cnt_d   = CNT_W'(RD_LATENCY - 1);
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          state_d = (op_q == OP_RMW) ? S_TURN : S_RESP;
          cnt_d   = CNT_W'(TURNAROUND - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_TURN: begin
        if (cnt_q == '0) state_d = S_WR;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A READ enters RESP on the same edge that captures the bus, so take the
  // response value straight from reg_data rather than from rdata_q.
  always_comb begin
    rsp_rdata_d = '0;
    if (state_q == S_RD_WAIT)
      rsp_rdata_d = reg_data;
    else if ((state_q == S_WR) && (op_q == OP_RMW))
      rsp_rdata_d = rdata_q;
  end

  assign wr_val = (op_q == OP_RMW) ? (rdata_q + wdata_q) : wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_ready <= (state_d == S_IDLE);
      rsp_valid <= (state_d == S_RESP);
      if (accept) begin
        op_q    <= cmd_op;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
      end
      if (rd_done)
        rdata_q <= reg_data;
      if (state_d == S_RESP) begin
        rsp_rdata <= rsp_rdata_d;
        rsp_err   <= (state_q == S_IDLE);
      end
    end
  end

  // Strobes and the bus enable decode from the async-reset state register, so
  // reset drops them immediately.
  assign busy     = (state_q != S_IDLE);
  assign reg_r    = (state_q == S_RD_ISSUE);
  assign reg_w    = (state_q == S_WR);
  assign reg_addr = addr_q;
  assign reg_data = (state_q == S_WR) ? wr_val : 'z;

endmodule

// File: tb/tb_reg_bus_master.sv
// Scoreboard bench for reg_bus_master with a behavioural 16x16 register file on the shared bus.
module tb_reg_bus_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic [3:0]  reg_addr;
  logic        reg_r;
  logic        reg_w;
  wire  [15:0] reg_data;

  pullup (reg_data);

  reg_bus_master #(
    .DATA_W    (16),
    .ADDR_W    (4),
    .RD_LATENCY(1),
    .TURNAROUND(1)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .reg_addr (reg_addr),
    .reg_r    (reg_r),
    .reg_w    (reg_w),
    .reg_data (reg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model: data valid one cycle after the reg_r cycle.
  logic [15:0] mem [16] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                            16'h0000, 16'h1234, 16'h0000, 16'h00F0,
                            16'h0000, 16'h0000, 16'h0000, 16'h0000,
                            16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
  logic        rf_drv = 1'b0;
  logic [3:0]  rf_addr = 4'h0;
  logic [15:0] rf_q;

  always @(posedge clk) begin
    if (reg_w) mem[reg_addr] <= reg_data;
    rf_drv  <= reg_r;
    rf_addr <= reg_addr;
  end
  assign rf_q     = mem[rf_addr];
  assign reg_data = rf_drv ? rf_q : 16'hzzzz;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endfunction

  typedef struct {
    string       name;
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  int          rd_pulses = 0;
  int          wr_pulses = 0;
  int          last_w_cyc = 0;
  int          last_rf_cyc = 0;
  int          last_rsp_cyc = 0;
  logic [15:0] last_w_data = '0;
  logic [3:0]  last_w_addr = '0;

  // Response monitor plus per-cycle bus protocol checks.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_rdata"}, rsp_rdata, e.rdata);
        chk({e.name, "_err"}, rsp_err, e.err);
        chk({e.name, "_latency"}, cyc - e.acc, e.lat);
      end
      last_rsp_cyc = cyc;
    end
    chk("rw_exclusive", reg_r & reg_w, 1'b0);
    if (rf_drv) begin
      chk("bus_contention", reg_w, 1'b0);
      chk("bus_rf_value", reg_data, rf_q);
      last_rf_cyc = cyc;
    end else if (!reg_w) begin
      chk("bus_release", reg_data, 16'hFFFF);
    end
    if (reg_r) rd_pulses++;
    if (reg_w) begin
      wr_pulses++;
      last_w_cyc  = cyc;
      last_w_data = reg_data;
      last_w_addr = reg_addr;
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(input string name, input logic [1:0] op, input logic [3:0] addr,
                       input logic [15:0] wd, input logic expect_rsp, input logic [15:0] exp_rdata,
                       input logic exp_err, input int exp_lat, input logic hold, output int acc);
    int   n;
    exp_t e;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_wdata = wd;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk({name, "_accept_timeout"}, 32'd1, 32'd0);
      cmd_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    chk({name, "_busy_at_accept"}, busy, 1'b0);
    if (expect_rsp) begin
      e.name  = name;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.lat   = exp_lat;
      e.acc   = acc;
      sb.push_back(e);
    end
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) begin
      chk({name, "_drain_timeout"}, 32'd1, 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    int acc, acc2, r0, w0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = 4'h0;
    cmd_wdata = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 16'h0000);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_reg_r", reg_r, 1'b0);
    chk("rst_reg_w", reg_w, 1'b0);
    chk("rst_reg_addr", reg_addr, 4'h0);
    chk("rst_bus", reg_data, 16'hFFFF);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", cmd_ready, 1'b0);
    @(negedge clk);
    chk("ready_after_edge", cmd_ready, 1'b1);

    // WRITE addr 3
    r0 = rd_pulses; w0 = wr_pulses;
    issue("wr3", 2'b01, 4'h3, 16'hBEEF, 1'b1, 16'h0000, 1'b0, 2, 1'b0, acc);
    wait_drain("wr3");
    chk("wr3_wpulses", wr_pulses - w0, 1);
    chk("wr3_rpulses", rd_pulses - r0, 0);
    chk("wr3_waddr", last_w_addr, 4'h3);
    chk("wr3_wdata", last_w_data, 16'hBEEF);
    chk("wr3_mem", mem[3], 16'hBEEF);

    // READ addr 3
    r0 = rd_pulses; w0 = wr_pulses;
    issue("rd3", 2'b00, 4'h3, 16'h0101, 1'b1, 16'hBEEF, 1'b0, 3, 1'b0, acc);
    wait_drain("rd3");
    chk("rd3_rpulses", rd_pulses - r0, 1);
    chk("rd3_wpulses", wr_pulses - w0, 0);

    // RMW_ADD on PC wraps FFFF+1 -> 0000
    r0 = rd_pulses; w0 = wr_pulses;
    issue("rmwF", 2'b10, 4'hF, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 5, 1'b0, acc);
    wait_drain("rmwF");
    chk("rmwF_rpulses", rd_pulses - r0, 1);
    chk("rmwF_wpulses", wr_pulses - w0, 1);
    chk("rmwF_wdata", last_w_data, 16'h0000);
    chk("rmwF_turn_gap", last_w_cyc - last_rf_cyc, 2);
    chk("rmwF_mem", mem[15], 16'h0000);

    // RMW_ADD accumulate
    issue("rmw7", 2'b10, 4'h7, 16'h0010, 1'b1, 16'h00F0, 1'b0, 5, 1'b0, acc);
    wait_drain("rmw7");
    chk("rmw7_mem", mem[7], 16'h0100);

    // Reserved op: no strobes, error response
    r0 = rd_pulses; w0 = wr_pulses;
    issue("rsvd", 2'b11, 4'h2, 16'h1234, 1'b1, 16'h0000, 1'b1, 1, 1'b0, acc);
    wait_drain("rsvd");
    chk("rsvd_rpulses", rd_pulses - r0, 0);
    chk("rsvd_wpulses", wr_pulses - w0, 0);
    chk("rsvd_mem", mem[2], 16'h0000);

    // Back-to-back with cmd_valid held high
    issue("b2b_wr", 2'b01, 4'h9, 16'hA5A5, 1'b1, 16'h0000, 1'b0, 2, 1'b1, acc);
    issue("b2b_rd", 2'b00, 4'h9, 16'h0202, 1'b1, 16'hA5A5, 1'b0, 3, 1'b0, acc2);
    chk("b2b_accept_after_resp", acc2 - last_rsp_cyc, 1);
    chk("b2b_accept_gap", acc2 - acc, 3);
    wait_drain("b2b");

    // Reset during the TURN cycle of an RMW_ADD
    w0 = wr_pulses;
    issue("rmw5", 2'b10, 4'h5, 16'h0001, 1'b0, 16'h0000, 1'b0, 0, 1'b0, acc);
    repeat (2) @(negedge clk);
    chk("rmw5_busy_in_turn", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_reg_w", reg_w, 1'b0);
    chk("midrst_reg_r", reg_r, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_cmd_ready", cmd_ready, 1'b0);
    chk("midrst_bus", reg_data, 16'hFFFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_wpulses", wr_pulses - w0, 0);
    chk("midrst_mem", mem[5], 16'h1234);
    issue("rd5", 2'b00, 4'h5, 16'h0303, 1'b1, 16'h1234, 1'b0, 3, 1'b0, acc);
    wait_drain("rd5");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
